// File: rtl/tt_sweep_pkg.sv
// Shared types, sizes and helpers for the truth-table sweep-and-capture stage.
package tt_sweep_pkg;

    localparam int N_IN_DEF = 3;
    localparam int ROWS     = 2 ** N_IN_DEF;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        CAPTURE,
        FINISH
    } sweep_state_e;

    // Counts set bits; callers zero-extend tables narrower than 32 bits.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/tt_row_timer.sv
// Settle counter for one stimulus row: loadable, decrements to zero and holds there.
module tt_row_timer
    import tt_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every stimulus combination into a datapath, waits a settle time per row,
// captures the result into a truth-table word and compares it with a golden word.
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter  int N_IN     = N_IN_DEF,
    parameter  int SETTLE   = 1,
    localparam int NUM_ROWS = 2 ** N_IN,
    localparam int MM_W     = N_IN + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                dut_out,
    input  logic [NUM_ROWS-1:0] expected,
    output logic [N_IN-1:0]     stim,
    output logic                busy,
    output logic                done,
    output logic [NUM_ROWS-1:0] table_out,
    output logic                match,
    output logic [MM_W-1:0]     mismatch_count
);

    // The timer counts the cycles still to wait after the first one of a row,
    // so SETTLE=0 skips HOLD entirely and every row is captured back to back.
    localparam logic [CNT_W-1:0] RELOAD    = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
    localparam bit               SKIP_HOLD = (SETTLE == 0);

    sweep_state_e        state_q, state_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic [NUM_ROWS-1:0] table_q, table_d;
    logic                match_q, match_d;
    logic [MM_W-1:0]     mm_q, mm_d;

    logic            timer_load;
    logic            timer_dec;
    logic            timer_zero;
    logic            last_row;
    logic            fin_match;
    logic [MM_W-1:0] fin_count;

    tt_row_timer u_row_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .dec      (timer_dec),
        .load_val (RELOAD),
        .zero     (timer_zero)
    );

    assign last_row  = &stim_q;
    assign fin_match = (table_q == expected);
    assign fin_count = MM_W'(popcount(32'(table_q ^ expected)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            stim_q  <= '0;
            table_q <= '0;
            match_q <= 1'b0;
            mm_q    <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            table_q <= table_d;
            match_q <= match_d;
            mm_q    <= mm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SKIP_HOLD ? CAPTURE : HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_zero) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_row) begin
                    state_d = FINISH;
                end else begin
                    state_d = SKIP_HOLD ? CAPTURE : HOLD;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Abort outranks capture; the partially filled table is deliberately kept.
    always_comb begin
        stim_d     = stim_q;
        table_d    = table_q;
        match_d    = match_q;
        mm_d       = mm_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    stim_d     = '0;
                    table_d    = '0;
                    match_d    = 1'b0;
                    mm_d       = '0;
                    timer_load = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    stim_d  = '0;
                    match_d = 1'b0;
                    mm_d    = '0;
                end else begin
                    timer_dec = !timer_zero;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    stim_d  = '0;
                    match_d = 1'b0;
                    mm_d    = '0;
                end else begin
                    table_d[stim_q] = dut_out;
                    if (last_row) begin
                        stim_d = '0;
                    end else begin
                        stim_d     = stim_q + N_IN'(1);
                        timer_load = 1'b1;
                    end
                end
            end
            FINISH: begin
                match_d = fin_match;
                mm_d    = fin_count;
            end
            default: begin
                stim_d = '0;
            end
        endcase
    end

    // In FINISH the comparison is shown live so it is valid alongside done.
    always_comb begin
        stim           = stim_q;
        table_out      = table_q;
        busy           = (state_q == HOLD) || (state_q == CAPTURE);
        done           = (state_q == FINISH);
        match          = (state_q == FINISH) ? fin_match : match_q;
        mismatch_count = (state_q == FINISH) ? fin_count : mm_q;
    end

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench: sweeps the OR/NOR + 2:1 mux datapath and checks every cycle
// against a truth-table reference model.
module tb_tt_sweep_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, abort0, dut_out0;
    logic [7:0] expected0, table0;
    logic [2:0] stim0;
    logic       busy0, done0, match0;
    logic [3:0] mm0;

    logic       start1, abort1;
    logic [7:0] expected1, table1;
    logic [2:0] stim1;
    logic       busy1, done1, match1;
    logic [3:0] mm1;

    int checks   = 0;
    int failures = 0;

    // Device under test: select chooses between OR(x,y) and NOR(x,y).
    logic or_xy, nor_xy;
    assign or_xy    = stim0[1] | stim0[0];
    assign nor_xy   = ~or_xy;
    assign dut_out0 = stim0[2] ? nor_xy : or_xy;

    tt_sweep_capture u_dut0 (
        .clk            (clk),
        .reset          (reset),
        .start          (start0),
        .abort          (abort0),
        .dut_out        (dut_out0),
        .expected       (expected0),
        .stim           (stim0),
        .busy           (busy0),
        .done           (done0),
        .table_out      (table0),
        .match          (match0),
        .mismatch_count (mm0)
    );

    tt_sweep_capture #(.SETTLE(0)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .start          (start1),
        .abort          (abort1),
        .dut_out        (1'b1),
        .expected       (expected1),
        .stim           (stim1),
        .busy           (busy1),
        .done           (done1),
        .table_out      (table1),
        .match          (match1),
        .mismatch_count (mm1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected_v);
        checks++;
        assert (observed === expected_v)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected_v);
        end
    endtask

    // Reference truth table: rows 0-3 are x OR y, rows 4-7 are x NOR y.
    function automatic logic [7:0] refTable();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) t[i] = ((i % 4) != 0);
            else       t[i] = ((i % 4) == 0);
        end
        return t;
    endfunction

    // One or more sweeps with SETTLE=1: each row lasts 2 cycles, done lands at
    // offset 16 after the start edge, and a held start retriggers every 18 cycles.
    task automatic applyStimulus(input logic [7:0] exp_word, input bit mid_pulse,
                                 input int n_sweeps);
        logic [7:0] tbl;
        int o;
        tbl = refTable();
        expected0 = exp_word;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 0; c < 18 * n_sweeps; c++) begin
            @(negedge clk);
            o = c % 18;
            if (c == 18 * (n_sweeps - 1)) start0 = 1'b0;
            if (mid_pulse && o == 5) start0 = 1'b1;
            if (mid_pulse && o == 6) start0 = 1'b0;
            if (o < 16) begin
                checkOutput("busy_sweep", busy0, 1);
                checkOutput("done_early", done0, 0);
                checkOutput("stim_step", stim0, o / 2);
            end else if (o == 16) begin
                checkOutput("done_pulse", done0, 1);
                checkOutput("busy_finish", busy0, 0);
                checkOutput("stim_finish", stim0, 0);
                checkOutput("table_finish", table0, tbl);
                checkOutput("match_finish", match0, (tbl == exp_word));
                checkOutput("mm_finish", mm0, $countones(tbl ^ exp_word));
            end else begin
                checkOutput("done_once", done0, 0);
                checkOutput("busy_idle", busy0, 0);
                checkOutput("table_hold", table0, tbl);
                checkOutput("match_hold", match0, (tbl == exp_word));
                checkOutput("mm_hold", mm0, $countones(tbl ^ exp_word));
            end
        end
    endtask

    task automatic abortTest(input int row, input int phase);
        logic [7:0] mask;
        mask = 8'((1 << row) - 1);
        expected0 = 8'h1E;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 0; c <= 2 * row + phase; c++) begin
            @(negedge clk);
            if (c == 0) start0 = 1'b0;
            checkOutput("abort_stim_pre", stim0, c / 2);
        end
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        checkOutput("abort_busy", busy0, 0);
        checkOutput("abort_stim", stim0, 0);
        checkOutput("abort_table", table0, refTable() & mask);
        checkOutput("abort_match", match0, 0);
        checkOutput("abort_mm", mm0, 0);
        for (int c = 0; c < 3; c++) begin
            checkOutput("abort_no_done", done0, 0);
            @(negedge clk);
        end
    endtask

    task automatic resetTest();
        expected0 = 8'h1E;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 0) start0 = 1'b0;
        end
        checkOutput("pre_reset_busy", busy0, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("areset_stim", stim0, 0);
        checkOutput("areset_busy", busy0, 0);
        checkOutput("areset_done", done0, 0);
        checkOutput("areset_table", table0, 0);
        checkOutput("areset_match", match0, 0);
        checkOutput("areset_mm", mm0, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic settleZeroTest(input logic [7:0] exp_word);
        int busy_cycles;
        busy_cycles = 0;
        expected1 = exp_word;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) start1 = 1'b0;
            if (busy1) busy_cycles++;
            if (c < 8) begin
                checkOutput("s0_stim", stim1, c);
                checkOutput("s0_done_early", done1, 0);
            end else if (c == 8) begin
                checkOutput("s0_done", done1, 1);
                checkOutput("s0_table", table1, 8'hFF);
                checkOutput("s0_match", match1, (exp_word == 8'hFF));
                checkOutput("s0_mm", mm1, $countones(~exp_word));
            end else begin
                checkOutput("s0_done_once", done1, 0);
            end
        end
        checkOutput("s0_busy_cycles", busy_cycles, 8);
    endtask

    initial begin
        logic [7:0] e;
        reset     = 1'b1;
        start0    = 1'b0;
        abort0    = 1'b0;
        start1    = 1'b0;
        abort1    = 1'b0;
        expected0 = 8'h00;
        expected1 = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_stim", stim0, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_table", table0, 0);
        checkOutput("rst_match", match0, 0);
        checkOutput("rst_mm", mm0, 0);
        checkOutput("rst_busy1", busy1, 0);
        reset = 1'b0;

        applyStimulus(8'h1E, 1'b0, 1);
        applyStimulus(8'h1F, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            e = 8'($urandom);
            if (i == 0) e = refTable() ^ 8'(1 << $urandom_range(0, 7));
            applyStimulus(e, 1'b0, 1);
        end
        applyStimulus(8'h1E, 1'b1, 1);
        applyStimulus(8'h1E, 1'b0, 2);

        abortTest(3, 0);
        applyStimulus(8'h1E, 1'b0, 1);
        abortTest(int'($urandom_range(1, 6)), int'($urandom_range(0, 1)));

        resetTest();
        applyStimulus(8'h1E, 1'b0, 1);

        settleZeroTest(8'hFF);
        settleZeroTest(8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
